// File: rtl/mem_dump_pkg.sv
// Shared state encoding, UART frame constants and ASCII helpers for mem_dump_tx.
// MEM_DUMP_HEX_ASCII_EN adds the ASCII-hex character-send state.
package mem_dump_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StAddr   = 3'd1;
  localparam state_t StLatch  = 3'd2;
  localparam state_t StSendHi = 3'd3;
  localparam state_t StSendLo = 3'd4;
  localparam state_t StNext   = 3'd5;
  localparam state_t StFin    = 3'd6;
`ifdef MEM_DUMP_HEX_ASCII_EN
  localparam state_t StSendChr = 3'd7;
`endif

  localparam logic        UartStart    = 1'b0;
  localparam logic        UartStop     = 1'b1;
  localparam int unsigned UartDataBits = 8;

  localparam logic [7:0] AsciiCr   = 8'h0D;
  localparam logic [7:0] AsciiLf   = 8'h0A;
  localparam logic [7:0] AsciiZero = 8'h30;
  localparam logic [7:0] AsciiA    = 8'h41;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) return AsciiZero + {4'd0, nib};
    return AsciiA + {4'd0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/mem_dump_tx_if.sv
// RAM read bus plus halt/status/serial signals of the memory dump transmitter.
// master is the dump block; slave is the surrounding system (RAM mux, processor, host link).
interface mem_dump_tx_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
);
  logic              halting;
  logic [DATA_W-1:0] m_q;
  logic [ADDR_W-1:0] m_addr;
  logic              busy;
  logic              done;
  logic              tx;

  modport master (input halting, m_q, output m_addr, busy, done, tx);
  modport slave  (output halting, m_q, input m_addr, busy, done, tx);
endinterface

// File: rtl/mem_dump_tx_uart_tx_byte.sv
// 8N1 byte serialiser: start pulse loads a byte, done pulses for one cycle at the end
// of the stop bit, ready is high whenever a new byte may be started.
module uart_tx_byte
  import mem_dump_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done,
  output logic       ready
);
  localparam int unsigned   CntW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  logic            r_busy;
  logic [CntW-1:0] r_baud;
  logic [3:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_tx;
  logic            r_done;

  // r_bit: 0 = start bit, 1..8 = data bits, 9 = stop bit
  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= UartStop;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (start) begin
          r_busy  <= 1'b1;
          r_baud  <= '0;
          r_bit   <= '0;
          r_shift <= data;
          r_tx    <= UartStart;
        end
      end else if (r_baud != CntLast) begin
        r_baud <= r_baud + 1'b1;
      end else begin
        r_baud <= '0;
        if (r_bit == 4'(UartDataBits + 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_bit <= r_bit + 4'd1;
          if (r_bit < 4'(UartDataBits)) begin
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
          end else begin
            r_tx <= UartStop;
          end
        end
      end
    end
  end

  assign tx    = r_tx;
  assign done  = r_done;
  assign ready = ~r_busy;

endmodule

// File: rtl/mem_dump_tx.sv
// Dumps WORD_COUNT main-RAM words from START_ADDR over an 8N1 UART on a rising halt edge.
// MEM_DUMP_HEX_ASCII_EN: send each word as 4 hex chars + CR LF instead of 2 raw bytes.
module mem_dump_tx
  import mem_dump_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned START_ADDR   = 0,
  parameter int unsigned WORD_COUNT   = 16
) (
  input logic           clock,
  input logic           reset,
  mem_dump_tx_if.master bus
);
  localparam logic [ADDR_W-1:0] AddrFirst = ADDR_W'(START_ADDR);

  state_t            r_state;
  logic              r_halting_q;
  logic              r_busy;
  logic              r_done;
  logic              r_sent;
  logic              r_start;
  logic [7:0]        r_byte;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_cnt;
  logic [DATA_W-1:0] r_word;

  logic w_trigger;
  logic w_byte_done;
  logic w_ready;
  logic w_tx;

  assign w_trigger = bus.halting & ~r_halting_q;

`ifdef MEM_DUMP_HEX_ASCII_EN
  logic [2:0] r_chr;
  logic [7:0] w_chr;

  always_comb begin
    w_chr = AsciiLf;
    case (r_chr)
      3'd0:    w_chr = hex_char(r_word[15:12]);
      3'd1:    w_chr = hex_char(r_word[11:8]);
      3'd2:    w_chr = hex_char(r_word[7:4]);
      3'd3:    w_chr = hex_char(r_word[3:0]);
      3'd4:    w_chr = AsciiCr;
      default: w_chr = AsciiLf;
    endcase
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= StIdle;
      r_halting_q <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sent      <= 1'b0;
      r_start     <= 1'b0;
      r_byte      <= '0;
      r_addr      <= AddrFirst;
      r_cnt       <= '0;
      r_word      <= '0;
`ifdef MEM_DUMP_HEX_ASCII_EN
      r_chr       <= '0;
`endif
    end else begin
      r_halting_q <= bus.halting;
      r_start     <= 1'b0;
      if (!bus.halting) r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_trigger) begin
            r_busy  <= 1'b1;
            r_addr  <= AddrFirst;
            r_cnt   <= '0;
            r_state <= (WORD_COUNT > 0) ? StAddr : StFin;
          end
        end
        StAddr: r_state <= StLatch;
        StLatch: begin
          r_word <= bus.m_q;
          r_sent <= 1'b0;
`ifdef MEM_DUMP_HEX_ASCII_EN
          r_chr   <= '0;
          r_state <= StSendChr;
`else
          r_state <= StSendHi;
`endif
        end
`ifdef MEM_DUMP_HEX_ASCII_EN
        StSendChr: begin
          if (!r_sent) begin
            if (w_ready) begin
              r_start <= 1'b1;
              r_byte  <= w_chr;
              r_sent  <= 1'b1;
            end
          end else if (w_byte_done) begin
            r_sent <= 1'b0;
            if (r_chr == 3'd5) begin
              r_chr   <= '0;
              r_state <= StNext;
            end else begin
              r_chr <= r_chr + 3'd1;
            end
          end
        end
`else
        StSendHi: begin
          if (!r_sent) begin
            if (w_ready) begin
              r_start <= 1'b1;
              r_byte  <= r_word[15:8];
              r_sent  <= 1'b1;
            end
          end else if (w_byte_done) begin
            r_sent  <= 1'b0;
            r_state <= StSendLo;
          end
        end
        StSendLo: begin
          if (!r_sent) begin
            if (w_ready) begin
              r_start <= 1'b1;
              r_byte  <= r_word[7:0];
              r_sent  <= 1'b1;
            end
          end else if (w_byte_done) begin
            r_sent  <= 1'b0;
            r_state <= StNext;
          end
        end
`endif
        StNext: begin
          r_cnt   <= r_cnt + 32'd1;
          r_addr  <= r_addr + 1'b1;
          r_state <= (r_cnt + 32'd1 == WORD_COUNT) ? StFin : StAddr;
        end
        StFin: begin
          r_busy  <= 1'b0;
          // A halt that already dropped mid-dump must not leave done set
          if (bus.halting) r_done <= 1'b1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clock (clock),
    .reset (reset),
    .start (r_start),
    .data  (r_byte),
    .tx    (w_tx),
    .done  (w_byte_done),
    .ready (w_ready)
  );

  assign bus.m_addr = r_addr;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.tx     = w_tx;

endmodule

// File: tb/tb_mem_dump_tx.sv
// Bench for mem_dump_tx: normal, address-wrapping and zero-length instances share one RAM;
// a UART decoder per tx line is compared against a byte/timing model built from RAM contents.
`timescale 1ns/1ps
module tb_mem_dump_tx;
  localparam int C   = 4;
  localparam int NCH = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        h [NCH];
  logic [15:0] q [NCH];
  logic [15:0] ram [4096];
  int          cyc = 0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mem_dump_tx_if #(.ADDR_W(12), .DATA_W(16)) bus0 ();
  mem_dump_tx_if #(.ADDR_W(12), .DATA_W(16)) bus1 ();
  mem_dump_tx_if #(.ADDR_W(12), .DATA_W(16)) bus2 ();

  assign bus0.halting = h[0];
  assign bus1.halting = h[1];
  assign bus2.halting = h[2];
  assign bus0.m_q     = q[0];
  assign bus1.m_q     = q[1];
  assign bus2.m_q     = q[2];

  // RAM is clocked on the inverted clock
  always @(negedge clock) begin
    q[0] <= ram[bus0.m_addr];
    q[1] <= ram[bus1.m_addr];
    q[2] <= ram[bus2.m_addr];
  end

  logic        tx_w   [NCH];
  logic        busy_w [NCH];
  logic        done_w [NCH];
  logic [11:0] addr_w [NCH];
  assign tx_w[0] = bus0.tx;       assign tx_w[1] = bus1.tx;       assign tx_w[2] = bus2.tx;
  assign busy_w[0] = bus0.busy;   assign busy_w[1] = bus1.busy;   assign busy_w[2] = bus2.busy;
  assign done_w[0] = bus0.done;   assign done_w[1] = bus1.done;   assign done_w[2] = bus2.done;
  assign addr_w[0] = bus0.m_addr; assign addr_w[1] = bus1.m_addr; assign addr_w[2] = bus2.m_addr;

  mem_dump_tx #(.CLKS_PER_BIT(C), .ADDR_W(12), .DATA_W(16), .START_ADDR(0), .WORD_COUNT(2))
    u_dut (.clock(clock), .reset(reset), .bus(bus0));
  mem_dump_tx #(.CLKS_PER_BIT(C), .ADDR_W(12), .DATA_W(16), .START_ADDR(4095), .WORD_COUNT(2))
    u_dut_wrap (.clock(clock), .reset(reset), .bus(bus1));
  mem_dump_tx #(.CLKS_PER_BIT(C), .ADDR_W(12), .DATA_W(16), .START_ADDR(0), .WORD_COUNT(0))
    u_dut_zero (.clock(clock), .reset(reset), .bus(bus2));

  function automatic int ch_start(input int ch);
    return (ch == 1) ? 4095 : 0;
  endfunction

  function automatic int ch_wc(input int ch);
    return (ch == 2) ? 0 : 2;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART decoder: samples mid-bit, records each byte and the cycle its start bit appeared
  logic       in_fr [NCH];
  int         fcnt  [NCH];
  int         t0    [NCH];
  logic [7:0] sh    [NCH];
  logic [7:0] rx_b  [NCH][64];
  int         rx_t  [NCH][64];
  int         rx_n  [NCH];

  initial begin
    for (int i = 0; i < NCH; i++) begin
      in_fr[i] = 1'b0; fcnt[i] = 0; rx_n[i] = 0; t0[i] = 0; sh[i] = '0;
    end
    forever begin
      @(negedge clock);
      for (int i = 0; i < NCH; i++) begin
        if (reset) begin
          in_fr[i] = 1'b0;
        end else if (!in_fr[i]) begin
          if (tx_w[i] === 1'b0) begin
            in_fr[i] = 1'b1; fcnt[i] = 0; t0[i] = cyc;
          end
        end else begin
          fcnt[i]++;
          if (fcnt[i] % C == C / 2) begin
            if (fcnt[i] / C == 0) begin
              check_eq("start_bit", {31'd0, tx_w[i]}, 32'd0);
            end else if (fcnt[i] / C <= 8) begin
              sh[i][fcnt[i] / C - 1] = tx_w[i];
            end else begin
              check_eq("stop_bit", {31'd0, tx_w[i]}, 32'd1);
              if (rx_n[i] < 64) begin
                rx_b[i][rx_n[i]] = sh[i];
                rx_t[i][rx_n[i]] = t0[i];
              end
              rx_n[i]++;
              in_fr[i] = 1'b0;
            end
          end
        end
      end
    end
  end

  // Reference: byte stream and start-bit cycles derived from RAM and trigger cycle
  logic [7:0] exp_b [64];
  int         exp_t [64];
  int         exp_n;

  function automatic logic [7:0] hex_ascii(input int v);
    return (v < 10) ? 8'(48 + v) : 8'(55 + v);
  endfunction

  task automatic build_exp(input int ch, input int trig);
    int t;
    int nb;
    logic [15:0] word;
    exp_n = 0;
    t = trig + 4;
`ifdef MEM_DUMP_HEX_ASCII_EN
    nb = 6;
`else
    nb = 2;
`endif
    for (int w = 0; w < ch_wc(ch); w++) begin
      word = ram[(ch_start(ch) + w) % 4096];
      for (int j = 0; j < nb; j++) begin
`ifdef MEM_DUMP_HEX_ASCII_EN
        if (j < 4) exp_b[exp_n] = hex_ascii((int'(word) >> (4 * (3 - j))) % 16);
        else exp_b[exp_n] = (j == 4) ? 8'h0D : 8'h0A;
`else
        exp_b[exp_n] = (j == 0) ? word[15:8] : word[7:0];
`endif
        exp_t[exp_n] = t;
        exp_n++;
        t += (j == nb - 1) ? 10 * C + 6 : 10 * C + 3;
      end
    end
  endtask

  // drop_at >= 0 lowers halting that many cycles into the dump
  task automatic run_dump(input int ch, input string tag, input int drop_at, output int lat);
    int trig;
    rx_n[ch] = 0;
    @(posedge clock);
    #1 h[ch] = 1'b1;
    trig = cyc + 1;
    build_exp(ch, trig);
    @(posedge clock);
    @(negedge clock);
    check_eq({tag, "_busy_rise"}, {31'd0, busy_w[ch]}, 32'd1);
    lat = 0;
    while (busy_w[ch] === 1'b1 && lat < 5000) begin
      @(negedge clock);
      lat++;
      if (lat == drop_at) h[ch] = 1'b0;
    end
    check_eq({tag, "_timeout"}, {31'd0, lat >= 5000}, 32'd0);
    check_eq({tag, "_nbytes"}, rx_n[ch], exp_n);
    for (int i = 0; i < exp_n && i < rx_n[ch] && i < 64; i++) begin
      check_eq({tag, "_byte"}, {24'd0, rx_b[ch][i]}, {24'd0, exp_b[i]});
      check_eq({tag, "_start_cyc"}, rx_t[ch][i], exp_t[i]);
    end
    check_eq({tag, "_done"}, {31'd0, done_w[ch]}, {31'd0, drop_at < 0});
    check_eq({tag, "_m_addr"}, {20'd0, addr_w[ch]}, (ch_start(ch) + ch_wc(ch)) % 4096);
  endtask

  task automatic drop_halt(input int ch);
    @(posedge clock);
    #1 h[ch] = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_eq("done_clear", {31'd0, done_w[ch]}, 32'd0);
  endtask

  int lat;
  int k;

  initial begin
    for (int i = 0; i < NCH; i++) h[i] = 1'b0;
    reset = 1'b1;
    repeat (5) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < NCH; i++) begin
      check_eq("rst_tx", {31'd0, tx_w[i]}, 32'd1);
      check_eq("rst_busy", {31'd0, busy_w[i]}, 32'd0);
      check_eq("rst_done", {31'd0, done_w[i]}, 32'd0);
      check_eq("rst_m_addr", {20'd0, addr_w[i]}, ch_start(i));
    end
    repeat (1000) @(negedge clock);
    check_eq("idle_quiet", rx_n[0] + rx_n[1] + rx_n[2], 0);
    check_eq("idle_busy", {31'd0, busy_w[0] | busy_w[1] | busy_w[2]}, 32'd0);

    ram[0] = 16'h1234;
    ram[1] = 16'hBEEF;
    run_dump(0, "fixed", -1, lat);
    repeat (200) @(negedge clock);
    check_eq("no_retrigger", rx_n[0], exp_n);
    check_eq("held_done", {31'd0, done_w[0]}, 32'd1);
    drop_halt(0);
    run_dump(0, "resend", -1, lat);
    drop_halt(0);

    ram[4095] = 16'h00A5;
    ram[0]    = 16'h5A00;
    run_dump(1, "wrap", -1, lat);
    drop_halt(1);

    run_dump(2, "zero", -1, lat);
    check_eq("zero_latency", lat, 1);
    check_eq("zero_tx", {31'd0, tx_w[2]}, 32'd1);
    drop_halt(2);

    for (int r = 0; r < 4; r++) begin
      ram[0]    = 16'($urandom);
      ram[1]    = 16'($urandom);
      ram[4095] = 16'($urandom);
      run_dump(0, "rand0", -1, lat);
      drop_halt(0);
      run_dump(1, "rand1", -1, lat);
      drop_halt(1);
    end

    ram[0] = 16'($urandom);
    ram[1] = 16'($urandom);
    run_dump(0, "hdrop", 60, lat);

    // Reset during the third data bit of the first byte abandons the dump
    ram[0] = 16'h1234;
    rx_n[0] = 0;
    @(posedge clock);
    #1 h[0] = 1'b1;
    k = 0;
    while (!(in_fr[0] && fcnt[0] >= 3 * C && fcnt[0] < 4 * C - 1) && k < 2000) begin
      @(negedge clock);
      k++;
    end
    check_eq("rst_mid_reach", {31'd0, k >= 2000}, 32'd0);
    @(posedge clock);
    #1 begin reset = 1'b1; h[0] = 1'b0; end
    @(posedge clock);
    @(negedge clock);
    check_eq("rst_mid_tx", {31'd0, tx_w[0]}, 32'd1);
    check_eq("rst_mid_busy", {31'd0, busy_w[0]}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (300) @(negedge clock);
    check_eq("rst_mid_nobytes", rx_n[0], 0);
    check_eq("rst_mid_idle", {31'd0, busy_w[0]}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
